// File: rtl/bus_cycle_sync.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_sync
// Purpose  : Brings the asynchronous 6809 bus cycle (E, R/W, address, data,
//            decoder select) into the clk domain and converts each selected
//            peripheral access into one-cycle read/write strobes. Owns MRDY
//            clock stretching so a slow read holds the CPU until the
//            peripheral reports valid data.
// Macro    : BUS_TIMEOUT_EN - when defined, a stretched read is force-released
//            after TIMEOUT_CYCLES clk cycles and o_timeout is set (sticky).
//
// Parameters
//   SYNC_STAGES     flop depth of every input synchroniser (values < 2 use 2)
//   TIMEOUT_CYCLES  read stretch limit in clk cycles, 1..255
//
// Ports
//   clk            internal oscillator clock
//   reset          synchronous, active-high
//   i_E            6809 E (async)
//   i_RW           6809 R/W, 1 = read (async)
//   i_ADDRESS_BUS  6809 address (async)
//   i_DATA         data bus as seen by the FPGA (async)
//   i_ce           decoder select for clocked peripherals (async)
//   i_ready        peripheral read data valid (clk domain)
//   o_rd_strobe    one-cycle read request
//   o_wr_strobe    one-cycle write request
//   o_addr         address latched at cycle start
//   o_wdata        write data latched at E fall
//   o_MRDY         0 = stretch CPU clock, 1 = ready
//   o_busy         FSM not idle
//   o_timeout      sticky read timeout flag (0 when BUS_TIMEOUT_EN undefined)
//
// Revision : 1.0  initial release
// ============================================================================
module bus_cycle_sync #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DATA,
    input  logic        i_ce,
    input  logic        i_ready,
    output logic        o_rd_strobe,
    output logic        o_wr_strobe,
    output logic [15:0] o_addr,
    output logic [7:0]  o_wdata,
    output logic        o_MRDY,
    output logic        o_busy,
    output logic        o_timeout
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int c_BUS_W      = 27;
    localparam int c_E_BIT      = 26;
    localparam int c_RW_BIT     = 25;
    localparam int c_CE_BIT     = 24;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_HOLD       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // All async inputs travel as one vector through the same number of
    // flops so address/data/RW/ce samples stay aligned with E.
    // The chain carries no reset: clearing it mid-cycle would fabricate an
    // E rising edge once reset drops while the CPU still holds E high.
    // ------------------------------------------------------------------
    logic [c_BUS_W-1:0] w_async_in;
    logic [c_BUS_W-1:0] r_sync [c_SYNC_DEPTH];
    logic [c_BUS_W-1:0] r_smp;
    logic               r_e_prev;
    logic [7:0]         r_data_hold;

    assign w_async_in = {i_E, i_RW, i_ce, i_ADDRESS_BUS, i_DATA};

    always_ff @(posedge clk) begin
        r_sync[0] <= w_async_in;
        for (int i = 1; i < c_SYNC_DEPTH; i++) begin
            r_sync[i] <= r_sync[i-1];
        end
    end

    // r_smp / r_e_prev are the last two synchronised samples used for the
    // edge comparison. r_data_hold keeps the data bus from the most recent
    // sample taken while E was high, which is what a write must capture.
    always_ff @(posedge clk) begin
        r_smp    <= r_sync[c_SYNC_DEPTH-1];
        r_e_prev <= r_smp[c_E_BIT];
        if (r_smp[c_E_BIT]) begin
            r_data_hold <= r_smp[7:0];
        end
    end

    logic        w_e_s;
    logic        w_rw_s;
    logic        w_ce_s;
    logic [15:0] w_addr_s;

    assign w_e_s    = r_smp[c_E_BIT];
    assign w_rw_s   = r_smp[c_RW_BIT];
    assign w_ce_s   = r_smp[c_CE_BIT];
    assign w_addr_s = r_smp[23:8];

    // ------------------------------------------------------------------
    // Registered edge detection
    // ------------------------------------------------------------------
    logic r_e_rise;
    logic r_e_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_rise <= 1'b0;
            r_e_fall <= 1'b0;
        end else begin
            r_e_rise <= w_e_s & ~r_e_prev;
            r_e_fall <= ~w_e_s & r_e_prev;
        end
    end

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rd_strobe;
    logic        w_rd_nxt;
    logic        r_wr_strobe;
    logic        w_wr_nxt;
    logic        r_mrdy;
    logic        w_mrdy_nxt;
    logic [15:0] r_addr;
    logic [15:0] w_addr_nxt;
    logic [7:0]  r_wdata;
    logic [7:0]  w_wdata_nxt;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rd_strobe <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_mrdy      <= 1'b1;
            r_addr      <= 16'h0000;
            r_wdata     <= 8'h00;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= 8'd0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rd_strobe <= w_rd_nxt;
            r_wr_strobe <= w_wr_nxt;
            r_mrdy      <= w_mrdy_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_mrdy_nxt  = r_mrdy;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
`ifdef BUS_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
`endif
        case (r_state)
            ST_IDLE: begin
                w_mrdy_nxt = 1'b1;
                if (r_e_rise && w_ce_s) begin
                    w_addr_nxt = w_addr_s;
                    if (w_rw_s) begin
                        // Strobe and MRDY low are registered together so the
                        // CPU is held from the same edge the request issues.
                        w_rd_nxt    = 1'b1;
                        w_mrdy_nxt  = 1'b0;
                        w_state_nxt = ST_READ_WAIT;
`ifdef BUS_TIMEOUT_EN
                        w_cnt_nxt   = 8'd0;
`endif
                    end else begin
                        w_state_nxt = ST_WRITE_WAIT;
                    end
                end
            end

            ST_READ_WAIT: begin
                // A ready seen while the strobe is still high belongs to an
                // earlier request and is ignored.
                if (i_ready && !r_rd_strobe) begin
                    w_mrdy_nxt  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
`ifdef BUS_TIMEOUT_EN
                else if (r_cnt == c_TO_LAST) begin
                    w_mrdy_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
`endif
            end

            ST_WRITE_WAIT: begin
                if (r_e_fall) begin
                    w_wdata_nxt = r_data_hold;
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (r_e_fall) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_mrdy_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_rd_strobe = r_rd_strobe;
    assign o_wr_strobe = r_wr_strobe;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_MRDY      = r_mrdy;
    assign o_busy      = (r_state != ST_IDLE);

`ifdef BUS_TIMEOUT_EN
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_sync
// Purpose  : Directed self-checking bench for bus_cycle_sync. Drives 6809
//            style E cycles and checks strobes, latched address/data, MRDY
//            stretching, reset behaviour and (with BUS_TIMEOUT_EN) timeout.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_cycle_sync;

    localparam int c_TO = 16;

    logic        clk;
    logic        reset;
    logic        i_E;
    logic        i_RW;
    logic [15:0] i_ADDRESS_BUS;
    logic [7:0]  i_DATA;
    logic        i_ce;
    logic        i_ready;
    logic        o_rd_strobe;
    logic        o_wr_strobe;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;
    logic        o_MRDY;
    logic        o_busy;
    logic        o_timeout;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int low_cnt  = 0;

    bus_cycle_sync #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_E           (i_E),
        .i_RW          (i_RW),
        .i_ADDRESS_BUS (i_ADDRESS_BUS),
        .i_DATA        (i_DATA),
        .i_ce          (i_ce),
        .i_ready       (i_ready),
        .o_rd_strobe   (o_rd_strobe),
        .o_wr_strobe   (o_wr_strobe),
        .o_addr        (o_addr),
        .o_wdata       (o_wdata),
        .o_MRDY        (o_MRDY),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (o_rd_strobe === 1'b1) rd_cnt++;
        if (o_wr_strobe === 1'b1) wr_cnt++;
        if (o_MRDY === 1'b0)      low_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        rd_cnt  = 0;
        wr_cnt  = 0;
        low_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(6);
        checks += 7;
        if (o_rd_strobe !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", o_rd_strobe); end
        if (o_wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", o_wr_strobe); end
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL reset_mrdy got=%b exp=1", o_MRDY); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        if (o_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", o_addr); end
        if (o_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", o_wdata); end
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_read();
        clear_counts();
        i_ADDRESS_BUS = 16'hF123;
        i_RW = 1'b1;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(4);
        checks += 2;
        if (o_rd_strobe !== 1'b0) begin failures++; $display("FAIL read_early_strobe got=%b exp=0", o_rd_strobe); end
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL read_early_mrdy got=%b exp=1", o_MRDY); end
        tick(1);
        checks += 4;
        if (o_rd_strobe !== 1'b1) begin failures++; $display("FAIL read_strobe got=%b exp=1", o_rd_strobe); end
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL read_mrdy_low got=%b exp=0", o_MRDY); end
        if (o_addr !== 16'hF123) begin failures++; $display("FAIL read_addr got=%h exp=f123", o_addr); end
        if (o_busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", o_busy); end
        tick(5);
        checks += 2;
        if (o_rd_strobe !== 1'b0) begin failures++; $display("FAIL read_strobe_width got=%b exp=0", o_rd_strobe); end
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL read_mrdy_wait got=%b exp=0", o_MRDY); end
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checks += 2;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL read_mrdy_release got=%b exp=1", o_MRDY); end
        if (o_busy !== 1'b1) begin failures++; $display("FAIL read_hold_busy got=%b exp=1", o_busy); end
        tick(3);
        checks += 1;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL read_hold_wait got=%b exp=1", o_busy); end
        i_E = 1'b0;
        tick(4);
        checks += 1;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL read_hold_early_exit got=%b exp=1", o_busy); end
        tick(1);
        checks += 3;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL read_idle got=%b exp=0", o_busy); end
        if (rd_cnt !== 1) begin failures++; $display("FAIL read_strobe_count got=%0d exp=1", rd_cnt); end
        if (low_cnt !== 6) begin failures++; $display("FAIL read_mrdy_low_cycles got=%0d exp=6", low_cnt); end
        i_ce = 1'b0;
        tick(10);
    endtask

    task automatic test_write();
        clear_counts();
        i_ADDRESS_BUS = 16'hA000;
        i_DATA = 8'hA5;
        i_RW = 1'b0;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(5);
        checks += 2;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", o_busy); end
        if (o_wr_strobe !== 1'b0) begin failures++; $display("FAIL write_early_strobe got=%b exp=0", o_wr_strobe); end
        tick(10);
        i_E = 1'b0;
        tick(4);
        checks += 1;
        if (o_wr_strobe !== 1'b0) begin failures++; $display("FAIL write_strobe_latency got=%b exp=0", o_wr_strobe); end
        tick(1);
        checks += 4;
        if (o_wr_strobe !== 1'b1) begin failures++; $display("FAIL write_strobe got=%b exp=1", o_wr_strobe); end
        if (o_wdata !== 8'hA5) begin failures++; $display("FAIL write_wdata got=%h exp=a5", o_wdata); end
        if (o_addr !== 16'hA000) begin failures++; $display("FAIL write_addr got=%h exp=a000", o_addr); end
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL write_mrdy got=%b exp=1", o_MRDY); end
        tick(1);
        checks += 5;
        if (o_wr_strobe !== 1'b0) begin failures++; $display("FAIL write_strobe_width got=%b exp=0", o_wr_strobe); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL write_idle got=%b exp=0", o_busy); end
        if (wr_cnt !== 1) begin failures++; $display("FAIL write_strobe_count got=%0d exp=1", wr_cnt); end
        if (rd_cnt !== 0) begin failures++; $display("FAIL write_no_rd got=%0d exp=0", rd_cnt); end
        if (low_cnt !== 0) begin failures++; $display("FAIL write_mrdy_never_low got=%0d exp=0", low_cnt); end
        i_ce = 1'b0;
        i_DATA = 8'h00;
        tick(10);
    endtask

    task automatic test_no_ce();
        clear_counts();
        i_ADDRESS_BUS = 16'h0100;
        i_RW = 1'b1;
        i_ce = 1'b0;
        i_E  = 1'b1;
        tick(12);
        i_E = 1'b0;
        tick(12);
        checks += 5;
        if (rd_cnt !== 0) begin failures++; $display("FAIL noce_rd got=%0d exp=0", rd_cnt); end
        if (wr_cnt !== 0) begin failures++; $display("FAIL noce_wr got=%0d exp=0", wr_cnt); end
        if (low_cnt !== 0) begin failures++; $display("FAIL noce_mrdy got=%0d exp=0", low_cnt); end
        if (o_addr !== 16'hA000) begin failures++; $display("FAIL noce_addr got=%h exp=a000", o_addr); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL noce_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        i_ADDRESS_BUS = 16'h1234;
        i_RW = 1'b1;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(5);
        checks += 1;
        if (o_rd_strobe !== 1'b1) begin failures++; $display("FAIL rstmid_pre_strobe got=%b exp=1", o_rd_strobe); end
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks += 5;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL rstmid_mrdy got=%b exp=1", o_MRDY); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        if (o_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr got=%h exp=0000", o_addr); end
        if (o_wdata !== 8'h00) begin failures++; $display("FAIL rstmid_wdata got=%h exp=00", o_wdata); end
        if (o_rd_strobe !== 1'b0) begin failures++; $display("FAIL rstmid_strobe got=%b exp=0", o_rd_strobe); end
        i_E  = 1'b0;
        i_ce = 1'b0;
        tick(10);
        clear_counts();
        i_ADDRESS_BUS = 16'h2222;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(5);
        checks += 3;
        if (o_rd_strobe !== 1'b1) begin failures++; $display("FAIL rstmid_next_strobe got=%b exp=1", o_rd_strobe); end
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL rstmid_next_mrdy got=%b exp=0", o_MRDY); end
        if (o_addr !== 16'h2222) begin failures++; $display("FAIL rstmid_next_addr got=%h exp=2222", o_addr); end
        tick(1);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checks += 1;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL rstmid_next_release got=%b exp=1", o_MRDY); end
        i_E  = 1'b0;
        tick(10);
        checks += 2;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_next_idle got=%b exp=0", o_busy); end
        if (rd_cnt !== 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", rd_cnt); end
        i_ce = 1'b0;
        tick(5);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        // 1 MHz E: 50 clk high, 50 clk low at a 10 ns clock.
        i_ADDRESS_BUS = 16'h8000;
        i_RW = 1'b1;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(5);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checks += 1;
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_strobe got=%b exp=0", o_MRDY); end
        tick(3);
        checks += 1;
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL b2b_still_wait got=%b exp=0", o_MRDY); end
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checks += 1;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b exp=1", o_MRDY); end
        tick(40);
        i_E = 1'b0;
        i_RW = 1'b0;
        i_ADDRESS_BUS = 16'h8001;
        i_DATA = 8'h3C;
        tick(50);
        i_E = 1'b1;
        tick(50);
        i_E = 1'b0;
        tick(50);
        checks += 6;
        if (rd_cnt !== 1) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=1", rd_cnt); end
        if (wr_cnt !== 1) begin failures++; $display("FAIL b2b_wr_count got=%0d exp=1", wr_cnt); end
        if (o_wdata !== 8'h3C) begin failures++; $display("FAIL b2b_wdata got=%h exp=3c", o_wdata); end
        if (o_addr !== 16'h8001) begin failures++; $display("FAIL b2b_addr got=%h exp=8001", o_addr); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", o_busy); end
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL b2b_mrdy got=%b exp=1", o_MRDY); end
        i_ce = 1'b0;
        i_DATA = 8'h00;
        tick(5);
    endtask

    task automatic test_timeout();
        clear_counts();
        i_ADDRESS_BUS = 16'h4000;
        i_RW = 1'b1;
        i_ce = 1'b1;
        i_E  = 1'b1;
        tick(5);
`ifdef BUS_TIMEOUT_EN
        tick(c_TO - 1);
        checks += 2;
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL to_early_mrdy got=%b exp=0", o_MRDY); end
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_early_flag got=%b exp=0", o_timeout); end
        tick(1);
        checks += 3;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL to_release got=%b exp=1", o_MRDY); end
        if (o_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", o_timeout); end
        if (o_busy !== 1'b1) begin failures++; $display("FAIL to_hold got=%b exp=1", o_busy); end
        i_E = 1'b0;
        tick(10);
        i_E = 1'b1;
        tick(6);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        i_E = 1'b0;
        tick(10);
        checks += 3;
        if (o_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", o_timeout); end
        if (rd_cnt !== 2) begin failures++; $display("FAIL to_rd_count got=%0d exp=2", rd_cnt); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL to_idle got=%b exp=0", o_busy); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks += 1;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_reset_clear got=%b exp=0", o_timeout); end
`else
        tick(300);
        checks += 3;
        if (o_MRDY !== 1'b0) begin failures++; $display("FAIL nto_wait_mrdy got=%b exp=0", o_MRDY); end
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL nto_flag got=%b exp=0", o_timeout); end
        if (o_busy !== 1'b1) begin failures++; $display("FAIL nto_busy got=%b exp=1", o_busy); end
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checks += 1;
        if (o_MRDY !== 1'b1) begin failures++; $display("FAIL nto_release got=%b exp=1", o_MRDY); end
        i_E = 1'b0;
        tick(10);
        checks += 2;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL nto_flag_after got=%b exp=0", o_timeout); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL nto_idle got=%b exp=0", o_busy); end
`endif
        i_ce = 1'b0;
        tick(5);
    endtask

    initial begin
        reset         = 1'b1;
        i_E           = 1'b0;
        i_RW          = 1'b1;
        i_ADDRESS_BUS = 16'h0000;
        i_DATA        = 8'h00;
        i_ce          = 1'b0;
        i_ready       = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_no_ce();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
